// File: rtl/farm_det_pkg.sv
// -----------------------------------------------------------------------------
// farm_det_pkg
// Shared definitions for the farm-road vehicle detector:
//   - state_t      : detector FSM encoding (IDLE, WAIT, SERVE, CLEAR)
//   - DEF_*        : default parameter values
//   - clog2_of()   : width helper used to size q_cnt and internal counters
//   - lamp_onehot(): lamp legality helper used by the optional error check
//                    (built only when FARM_DET_ERR_EN is defined)
// -----------------------------------------------------------------------------
package farm_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SERVE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam int DEF_DEB_CYCLES   = 3;
    localparam int DEF_QMAX         = 15;
    localparam int DEF_DRAIN_CYCLES = 2;

    // Number of bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int clog2_of(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // True when exactly one of {fg, fy, fr} is lit.
    function automatic logic lamp_onehot(input logic [2:0] lamps);
        return (lamps == 3'b001) || (lamps == 3'b010) || (lamps == 3'b100);
    endfunction

endpackage

// File: rtl/loop_debounce.sv
// -----------------------------------------------------------------------------
// loop_debounce
// Synchronizes the raw inductive-loop level and debounces it. The filtered
// level changes only after DEB_CYCLES consecutive synchronized samples that
// disagree with it; a registered one-cycle pulse marks each rising change.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   loop_raw     in   raw loop level (asynchronous, noisy)
//   arrive_pulse out  high for the first cycle in which the filtered level is 1
// -----------------------------------------------------------------------------
module loop_debounce
    import farm_det_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic loop_raw,
    output logic arrive_pulse
);

    localparam int CW = clog2_of(DEB_CYCLES + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          filt_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchronizer for the asynchronous loop input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= loop_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter: counts consecutive disagreeing samples, flips the
    // filtered level when the run reaches DEB_CYCLES, and flags rising flips.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= {CW{1'b0}};
            filt_r       <= 1'b0;
            arrive_pulse <= 1'b0;
        end else if (sync2_r == filt_r) begin
            cnt_r        <= {CW{1'b0}};
            arrive_pulse <= 1'b0;
        end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
            // This sample would make the run DEB_CYCLES long.
            cnt_r        <= {CW{1'b0}};
            filt_r       <= sync2_r;
            arrive_pulse <= sync2_r;
        end else begin
            cnt_r        <= cnt_r + CW'(1);
            arrive_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/farm_road_detector.sv
// -----------------------------------------------------------------------------
// farm_road_detector
// Farm-road vehicle detector front end. Debounces the loop input, keeps a
// saturating count of queued vehicles, drains one vehicle per DRAIN_CYCLES
// cycles of farm green, and raises the request c while vehicles are waiting.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   loop_raw     in   raw loop-detector level (asynchronous, noisy)
//   fg, fy, fr   in   farm-road green / yellow / red from the controller
//   c            out  farm-road request (from registered state and count)
//   q_cnt        out  number of queued vehicles, saturates at QMAX
//   arrive_pulse out  one-cycle pulse per debounced arrival
//   err          out  sticky illegal-lamp flag
//
// Optional feature: define FARM_DET_ERR_EN to build the lamp checker. Without
// it err is tied low and no check logic exists.
// -----------------------------------------------------------------------------
module farm_road_detector
    import farm_det_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int QMAX         = DEF_QMAX,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int QW           = clog2_of(QMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          loop_raw,
    input  logic          fg,
    input  logic          fy,
    input  logic          fr,
    output logic          c,
    output logic [QW-1:0] q_cnt,
    output logic          arrive_pulse,
    output logic          err
);

    localparam int TW = clog2_of(DRAIN_CYCLES + 1);

    state_t        state_r;
    state_t        state_s;
    logic [QW-1:0] q_next_s;
    logic [TW-1:0] timer_r;
    logic          depart_s;
    logic          queued_s;

    loop_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .loop_raw     (loop_raw),
        .arrive_pulse (arrive_pulse)
    );

    assign queued_s = (q_cnt != {QW{1'b0}});

    // Departure strobe: one vehicle leaves when a full drain period of green
    // has elapsed and someone is queued.
    always_comb begin
        depart_s = 1'b0;
        if ((state_r == ST_SERVE) && (timer_r == TW'(DRAIN_CYCLES - 1)) && queued_s) begin
            depart_s = 1'b1;
        end else begin
            depart_s = 1'b0;
        end
    end

    // Next queue count: arrival and departure together cancel, including at
    // QMAX; a lone arrival saturates.
    always_comb begin
        q_next_s = q_cnt;
        if (arrive_pulse && !depart_s) begin
            if (q_cnt != QW'(QMAX)) begin
                q_next_s = q_cnt + QW'(1);
            end else begin
                q_next_s = q_cnt;
            end
        end else if (!arrive_pulse && depart_s) begin
            q_next_s = q_cnt - QW'(1);
        end else begin
            q_next_s = q_cnt;
        end
    end

    // Queue count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt <= {QW{1'b0}};
        end else begin
            q_cnt <= q_next_s;
        end
    end

    // Drain timer. Held at zero outside SERVE so the first SERVE cycle starts
    // from zero; it counts up to DRAIN_CYCLES-1, restarts on each departure and
    // parks at the top while the queue is empty so a late arrival leaves on the
    // following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= {TW{1'b0}};
        end else if (state_r != ST_SERVE) begin
            timer_r <= {TW{1'b0}};
        end else if (timer_r == TW'(DRAIN_CYCLES - 1)) begin
            if (queued_s) begin
                timer_r <= {TW{1'b0}};
            end else begin
                timer_r <= timer_r;
            end
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // FSM next state. In IDLE a pending queue takes precedence over an
    // unrequested green; yellow takes precedence over red while serving.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (queued_s) begin
                    state_s = ST_WAIT;
                end else if (fg) begin
                    state_s = ST_SERVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (fg) begin
                    state_s = ST_SERVE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_SERVE: begin
                if (fy) begin
                    state_s = ST_CLEAR;
                end else if (fr) begin
                    state_s = queued_s ? ST_WAIT : ST_IDLE;
                end else begin
                    state_s = ST_SERVE;
                end
            end
            ST_CLEAR: begin
                if (fr) begin
                    state_s = queued_s ? ST_WAIT : ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request: decoded from registered state and count only, so c drops in
    // the cycle the last queued vehicle departs.
    assign c = (state_r == ST_WAIT) | ((state_r == ST_SERVE) & queued_s);

`ifdef FARM_DET_ERR_EN
    logic err_r;

    // Sticky lamp checker: non-one-hot lamps, or yellow while not serving.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (!lamp_onehot({fg, fy, fr}) ||
                     (fy && ((state_r == ST_IDLE) || (state_r == ST_WAIT)))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_farm_road_detector.sv
// -----------------------------------------------------------------------------
// tb_farm_road_detector
// Directed scenarios plus randomized loop noise and lamp sequences, compared
// every cycle against a behavioural model of the detector.
// -----------------------------------------------------------------------------
module tb_farm_road_detector;

    localparam int DEB   = 3;
    localparam int QMAX  = 15;
    localparam int DRAIN = 2;
    localparam int QW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          loop_raw;
    logic          fg;
    logic          fy;
    logic          fr;
    logic          c;
    logic [QW-1:0] q_cnt;
    logic          arrive_pulse;
    logic          err;

    int total = 0;
    int bad   = 0;
    int hold  = 0;

    always #5 clk = ~clk;

    farm_road_detector #(
        .DEB_CYCLES   (DEB),
        .QMAX         (QMAX),
        .DRAIN_CYCLES (DRAIN),
        .QW           (QW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .loop_raw     (loop_raw),
        .fg           (fg),
        .fy           (fy),
        .fr           (fr),
        .c            (c),
        .q_cnt        (q_cnt),
        .arrive_pulse (arrive_pulse),
        .err          (err)
    );

    // ---------------- behavioural reference model ----------------
    typedef enum {M_QUIET, M_WANT, M_GREEN, M_AMBER} mode_t;

    mode_t m_mode = M_QUIET;
    mode_t nm;
    bit    m_s1, m_s2, m_filt, m_pulse, m_err;
    bit    arr, dep, all_diff;
    int    m_q   = 0;
    int    m_age = 0;
    bit    sq[$];

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_filt = 1'b0; m_pulse = 1'b0; m_err = 1'b0;
            m_q = 0; m_age = 0; m_mode = M_QUIET;
            sq.delete();
        end else begin
`ifdef FARM_DET_ERR_EN
            if ((int'(fg) + int'(fy) + int'(fr)) != 1) m_err = 1'b1;
            if (fy && (m_mode == M_QUIET || m_mode == M_WANT)) m_err = 1'b1;
`endif
            // debounce: last DEB synchronized samples all disagree -> flip
            arr     = m_pulse;
            m_pulse = 1'b0;
            sq.push_back(m_s2);
            if (sq.size() > DEB) void'(sq.pop_front());
            all_diff = (sq.size() == DEB);
            foreach (sq[i]) if (sq[i] == m_filt) all_diff = 1'b0;
            if (all_diff) begin
                m_filt  = ~m_filt;
                m_pulse = m_filt;
                sq.delete();
            end
            m_s2 = m_s1;
            m_s1 = loop_raw;
            // one departure per DRAIN green cycles, counted from entry
            dep = 1'b0;
            if (m_mode == M_GREEN) begin
                if (m_age < DRAIN) m_age++;
                if (m_age == DRAIN && m_q > 0) begin
                    dep   = 1'b1;
                    m_age = 0;
                end
            end
            nm = m_mode;
            case (m_mode)
                M_QUIET: if (m_q != 0) nm = M_WANT; else if (fg) nm = M_GREEN;
                M_WANT:  if (fg) nm = M_GREEN;
                M_GREEN: if (fy) nm = M_AMBER; else if (fr) nm = (m_q != 0) ? M_WANT : M_QUIET;
                M_AMBER: if (fr) nm = (m_q != 0) ? M_WANT : M_QUIET;
                default: nm = M_QUIET;
            endcase
            if (nm == M_GREEN && m_mode != M_GREEN) m_age = 0;
            if (arr && dep) m_q = m_q;
            else if (arr)   m_q = (m_q < QMAX) ? m_q + 1 : QMAX;
            else if (dep)   m_q = m_q - 1;
            m_mode = nm;
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and compare every output with the model.
    task automatic step();
        @(negedge clk);
        check_val("q_cnt", int'(q_cnt), m_q);
        check_val("c", int'(c), int'((m_mode == M_WANT) || (m_mode == M_GREEN && m_q != 0)));
        check_val("arrive_pulse", int'(arrive_pulse), int'(m_pulse));
        check_val("err", int'(err), int'(m_err));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_lamps(input logic g, input logic y, input logic r);
        fg = g; fy = y; fr = r;
    endtask

    task automatic vehicle();
        loop_raw = 1'b1;
        steps(6);
        loop_raw = 1'b0;
        steps(6);
    endtask

    // Random loop level with random hold times.
    task automatic noisy(input int n);
        for (int i = 0; i < n; i++) begin
            if (hold == 0) begin
                loop_raw = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 9);
            end
            hold--;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; loop_raw = 1'b0;
        set_lamps(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_q", int'(q_cnt), 0);
        check_val("rst_c", int'(c), 0);
        check_val("rst_pulse", int'(arrive_pulse), 0);
        check_val("rst_err", int'(err), 0);
        rst = 1'b0;

        // clean arrival: loop first sampled at edge 0
        loop_raw = 1'b1;
        steps(5);
        check_val("arr_pulse_e4", int'(arrive_pulse), 1);
        check_val("arr_q_e4", int'(q_cnt), 0);
        step();
        check_val("arr_q_e5", int'(q_cnt), 1);
        check_val("arr_pulse_e5", int'(arrive_pulse), 0);
        check_val("arr_c_e5", int'(c), 0);
        step();
        check_val("arr_c_e6", int'(c), 1);
        loop_raw = 1'b0;
        steps(6);
        vehicle();
        vehicle();
        check_val("queue3", int'(q_cnt), 3);

        // drain three vehicles under green
        set_lamps(1'b1, 1'b0, 1'b0);
        step();
        check_val("drain_c_entry", int'(c), 1);
        steps(2);
        check_val("drain_q_e2", int'(q_cnt), 2);
        steps(2);
        check_val("drain_q_e4", int'(q_cnt), 1);
        step();
        check_val("drain_c_e5", int'(c), 1);
        step();
        check_val("drain_q_e6", int'(q_cnt), 0);
        check_val("drain_c_e6", int'(c), 0);

        // arrival during yellow, then red -> request again
        set_lamps(1'b0, 1'b1, 1'b0);
        step();
        loop_raw = 1'b1;
        steps(6);
        check_val("clear_q", int'(q_cnt), 1);
        check_val("clear_c", int'(c), 0);
        loop_raw = 1'b0;
        set_lamps(1'b0, 1'b0, 1'b1);
        step();
        check_val("clear_fr_c", int'(c), 1);
        steps(6);
        set_lamps(1'b1, 1'b0, 1'b0);
        steps(4);
        check_val("drain_last_q", int'(q_cnt), 0);
        set_lamps(1'b0, 1'b1, 1'b0);
        step();
        set_lamps(1'b0, 1'b0, 1'b1);
        steps(3);

        // glitch filtering
        for (int g = 0; g < 10; g++) begin
            loop_raw = 1'b1;
            steps(2);
            loop_raw = 1'b0;
            steps(4);
        end
        check_val("glitch_q", int'(q_cnt), 0);
        check_val("glitch_c", int'(c), 0);

        // saturation
        for (int v = 0; v < 17; v++) vehicle();
        check_val("sat_q", int'(q_cnt), QMAX);

        // arrival coinciding with the third-edge-pair departure
        set_lamps(1'b1, 1'b0, 1'b0);
        step();
        loop_raw = 1'b1;
        step();
        step();
        check_val("simul_q_e2", int'(q_cnt), 14);
        steps(2);
        check_val("simul_q_e4", int'(q_cnt), 13);
        steps(2);
        check_val("simul_q_e6", int'(q_cnt), 13);
        steps(2);
        check_val("simul_q_e8", int'(q_cnt), 12);
        loop_raw = 1'b0;
        steps(4);

        // randomized lamp rounds with noisy loop
        for (int r = 0; r < 60; r++) begin
            set_lamps(1'b0, 1'b0, 1'b1);
            noisy($urandom_range(2, 20));
            set_lamps(1'b1, 1'b0, 1'b0);
            noisy($urandom_range(1, 25));
            set_lamps(1'b0, 1'b1, 1'b0);
            noisy($urandom_range(1, 4));
        end
        set_lamps(1'b0, 1'b0, 1'b1);
        loop_raw = 1'b0;
        steps(8);

        // reset while serving with the loop held high
        set_lamps(1'b1, 1'b0, 1'b0);
        loop_raw = 1'b1;
        steps(3);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_q", int'(q_cnt), 0);
        check_val("mid_rst_c", int'(c), 0);
        check_val("mid_rst_pulse", int'(arrive_pulse), 0);
        rst = 1'b0;
        steps(5);
        check_val("post_rst_pulse", int'(arrive_pulse), 1);
        check_val("post_rst_q5", int'(q_cnt), 0);
        step();
        check_val("post_rst_q6", int'(q_cnt), 1);
        loop_raw = 1'b0;
        steps(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
